// File: rtl/mem_sig_responder.sv
// Word-memory responder for the SoC mem_* SRAM port, with signature decode for
// the stop request (timed drain to done) and integer-register dumps into a FIFO.
module mem_sig_responder #(
  parameter int ADDR_WIDTH        = 21,
  parameter int DATA_WIDTH        = 128,
  parameter int MEM_DEPTH_LOG2    = 16,
  parameter int STOP_ADDR         = 0,
  parameter int DUMP_ADDR         = 1,
  parameter int DUMP_FIFO_DEPTH   = 8,
  parameter int STOP_DRAIN_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [DATA_WIDTH-1:0] mem_strb_i,
  input  logic                  mem_we_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  dump_valid_o,
  output logic [4:0]            dump_idx_o,
  output logic [63:0]           dump_data_o,
  input  logic                  dump_ready_i,
  output logic                  dump_overflow_o,
  output logic                  stop_req_o,
  output logic                  done_o
);

  localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;
  localparam int PTR_W     = $clog2(DUMP_FIFO_DEPTH);
  localparam int CNT_W     = (STOP_DRAIN_CYCLES > 1) ? $clog2(STOP_DRAIN_CYCLES) : 1;
  localparam int ENTRY_W   = 5 + 64;

  localparam logic [ADDR_WIDTH-1:0] STOP_A     = ADDR_WIDTH'(STOP_ADDR);
  localparam logic [ADDR_WIDTH-1:0] DUMP_A     = ADDR_WIDTH'(DUMP_ADDR);
  localparam logic [PTR_W:0]        FIFO_FULL  = (PTR_W+1)'(DUMP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      DRAIN_LOAD = CNT_W'(STOP_DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // FSM state is kept as a plainly named register so checkers can bind to it.
  state_t             state;
  logic [CNT_W-1:0]   drain_cnt;

  logic [DATA_WIDTH-1:0]     mem [MEM_WORDS];
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;

  logic is_stop;
  logic is_dump;
  logic is_sig;
  logic rd_en;
  logic mem_wr_en;
  logic stop_wr;
  logic dump_wr;

  assign mem_idx   = mem_addr_i[MEM_DEPTH_LOG2-1:0];
  assign is_stop   = (mem_addr_i == STOP_A);
  assign is_dump   = (mem_addr_i == DUMP_A);
  assign is_sig    = is_stop | is_dump;
  assign rd_en     = mem_req_i & ~mem_we_i;
  assign mem_wr_en = mem_req_i & mem_we_i & ~is_sig;
  assign stop_wr   = mem_req_i & mem_we_i & is_stop;
  assign dump_wr   = mem_req_i & mem_we_i & is_dump & (state == ST_RUN);

  // Storage is intentionally unreset so benches can preload it.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_idx] <= (mem[mem_idx] & ~mem_strb_i) | (mem_wdata_i & mem_strb_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata_o <= '0;
    end else if (rd_en) begin
      mem_rdata_o <= is_sig ? '0 : mem[mem_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      stop_req_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (stop_wr) begin
            state      <= ST_DRAIN;
            stop_req_o <= 1'b1;
            drain_cnt  <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Dump handshake: an entry transfers on a rising clk edge where dump_valid_o
  // and dump_ready_i are both high; dump_valid_o never drops without a transfer,
  // and head idx/data stay stable while valid and not yet accepted.
  logic [ENTRY_W-1:0] fifo_mem [DUMP_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_cnt;
  logic [4:0]         next_idx;
  logic [ENTRY_W-1:0] last_pop;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;

  assign fifo_full = (fifo_cnt == FIFO_FULL);
  assign pop       = dump_valid_o & dump_ready_i;
  assign push      = dump_wr & (~fifo_full | pop);
  assign drop      = dump_wr & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {next_idx, mem_wdata_i[63:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      next_idx        <= 5'd1;
      last_pop        <= '0;
      dump_overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // Register numbering advances even for dropped dumps so gaps stay visible.
      if (dump_wr) begin
        next_idx <= (next_idx == 5'd31) ? 5'd1 : next_idx + 5'd1;
      end
      if (drop) begin
        dump_overflow_o <= 1'b1;
      end
    end
  end

  assign dump_valid_o = (fifo_cnt != '0);
  assign {dump_idx_o, dump_data_o} = dump_valid_o ? fifo_mem[rd_ptr] : last_pop;

endmodule
